// File: rtl/gp_writeback_arbiter.sv
// Writeback arbiter for the GP register file write port: ALU results vs. load
// returns, with anti-starvation for the ALU and a pending-load scoreboard.
module gp_writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_idx,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_idx,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_idx,
  input  logic [4:0]  query_idx_1,
  input  logic [4:0]  query_idx_2,
  output logic        busy_1,
  output logic        busy_2,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_idx,
  output logic [31:0] rf_write_data,
  output logic        protocol_error
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        alu_grant;
  logic        mem_grant;
  logic        issue_live;
  logic        issue_err;

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_valid && mem_valid) begin
      if (starve_cnt == LIMIT) alu_grant = 1'b1;
      else                     mem_grant = 1'b1;
    end else begin
      alu_grant = alu_valid;
      mem_grant = mem_valid;
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!alu_valid || alu_grant) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Index 0 still completes its handshake but never reaches the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_idx    <= 5'd0;
      rf_write_data   <= 32'd0;
    end else if (alu_grant) begin
      rf_write_enable <= (alu_idx != 5'd0);
      rf_write_idx    <= alu_idx;
      rf_write_data   <= alu_data;
    end else if (mem_grant) begin
      rf_write_enable <= (mem_idx != 5'd0);
      rf_write_idx    <= mem_idx;
      rf_write_data   <= mem_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  assign issue_live = issue_valid && (issue_idx != 5'd0);

  // Set wins over a same-cycle clear: the newly issued load is the one outstanding.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (issue_live) set_vec[issue_idx] = 1'b1;
    if (mem_grant)  clr_vec[mem_idx]   = 1'b1;
    pending_nxt = ((pending & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    issue_err   = issue_live && pending[issue_idx] && !clr_vec[issue_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending        <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (issue_err) protocol_error <= 1'b1;
    end
  end

  assign busy_1 = pending[query_idx_1];
  assign busy_2 = pending[query_idx_2];

endmodule

// File: tb/tb_gp_writeback_arbiter.sv
// Self-checking bench for gp_writeback_arbiter: directed scenarios plus a
// randomized run against a behavioural scoreboard/arbitration model.
module tb_gp_writeback_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_idx, mem_idx, issue_idx, query_idx_1, query_idx_2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy_1, busy_2;
  logic        rf_write_enable, protocol_error;
  logic [4:0]  rf_write_idx;
  logic [31:0] rf_write_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit          m_pend [32];
  int          m_starve;
  bit          m_we, m_perr;
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  gp_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .query_idx_1(query_idx_1), .query_idx_2(query_idx_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .rf_write_enable(rf_write_enable), .rf_write_idx(rf_write_idx),
    .rf_write_data(rf_write_data), .protocol_error(protocol_error)
  );

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_starve = 0; m_we = 0; m_perr = 0; m_idx = '0; m_data = '0;
  endfunction

  // 0 = nobody, 1 = ALU, 2 = load return
  function automatic int model_grant();
    if (alu_valid && mem_valid) return (m_starve == LIMIT) ? 1 : 2;
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  function automatic void model_update(int g);
    if (issue_valid && issue_idx != 0 && m_pend[issue_idx] && !(g == 2 && mem_idx == issue_idx))
      m_perr = 1;
    if (g == 2) m_pend[mem_idx] = 0;
    if (issue_valid && issue_idx != 0) m_pend[issue_idx] = 1;
    if (!alu_valid || g == 1) m_starve = 0;
    else if (m_starve < LIMIT) m_starve = m_starve + 1;
    if (g == 1) begin
      m_we = (alu_idx != 0); m_idx = alu_idx; m_data = alu_data;
    end else if (g == 2) begin
      m_we = (mem_idx != 0); m_idx = mem_idx; m_data = mem_data;
    end else begin
      m_we = 0;
    end
  endfunction

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_idx = '0; mem_idx = '0; issue_idx = '0; alu_data = '0; mem_data = '0;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    model_update(g);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rf_write_enable !== 1'b0 || rf_write_idx !== 5'd0 || rf_write_data !== 32'd0 ||
        protocol_error !== 1'b0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: we=%b idx=%0d data=%h perr=%b busy=%b%b, required all zero",
               rf_write_enable, rf_write_idx, rf_write_data, protocol_error, busy_1, busy_2);
    end
  endtask

  task automatic test_alu_alone();
    idle(); alu_valid = 1; alu_idx = 5; alu_data = 32'h0000_1234; #1;
    n_cmp++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_err++; $display("FAIL alu_alone_ready: alu_ready=%b mem_ready=%b, required 1 0", alu_ready, mem_ready);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rf_write_enable !== 1'b1 || rf_write_idx !== 5'd5 || rf_write_data !== 32'h0000_1234) begin
      n_err++; $display("FAIL alu_alone_write: we=%b idx=%0d data=%h, required 1 5 00001234",
                        rf_write_enable, rf_write_idx, rf_write_data);
    end
    tick();
    n_cmp++;
    if (rf_write_enable !== 1'b0 || rf_write_idx !== 5'd5) begin
      n_err++; $display("FAIL alu_alone_idle: we=%b idx=%0d, required 0 5 (held)", rf_write_enable, rf_write_idx);
    end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 6; c++) begin
      idle();
      alu_valid = 1; alu_idx = 6; alu_data = 32'hA000_0000 + 32'(c);
      mem_valid = 1; mem_idx = 5'(3 + c); mem_data = 32'hB000_0000 + 32'(c);
      #1;
      n_cmp++;
      if (alu_ready !== (c == 4) || mem_ready !== (c != 4)) begin
        n_err++; $display("FAIL starve_cycle%0d: alu_ready=%b mem_ready=%b, required %b %b",
                          c, alu_ready, mem_ready, c == 4, c != 4);
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1; issue_idx = 7; query_idx_1 = 7; #1;
    n_cmp++;
    if (busy_1 !== 1'b0) begin
      n_err++; $display("FAIL sb_same_cycle: busy_1=%b, required 0", busy_1);
    end
    tick(); idle();
    for (int c = 1; c < 3; c++) begin
      #1; n_cmp++;
      if (busy_1 !== 1'b1) begin
        n_err++; $display("FAIL sb_busy_cycle%0d: busy_1=%b, required 1", c, busy_1);
      end
      tick();
    end
    mem_valid = 1; mem_idx = 7; mem_data = 32'hDEAD_BEEF; #1;
    n_cmp++;
    if (mem_ready !== 1'b1 || busy_1 !== 1'b1) begin
      n_err++; $display("FAIL sb_grant: mem_ready=%b busy_1=%b, required 1 1", mem_ready, busy_1);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rf_write_enable !== 1'b1 || rf_write_idx !== 5'd7 || rf_write_data !== 32'hDEAD_BEEF || busy_1 !== 1'b0) begin
      n_err++; $display("FAIL sb_clear: we=%b idx=%0d data=%h busy_1=%b, required 1 7 deadbeef 0",
                        rf_write_enable, rf_write_idx, rf_write_data, busy_1);
    end
  endtask

  task automatic test_zero_reg();
    idle(); alu_valid = 1; alu_idx = 0; alu_data = 32'h5555_5555; #1;
    n_cmp++;
    if (alu_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_ready: alu_ready=%b, required 1", alu_ready);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin
      n_err++; $display("FAIL zero_write: we=%b, required 0", rf_write_enable);
    end
    for (int c = 0; c < 2; c++) begin
      issue_valid = 1; issue_idx = 0; query_idx_1 = 0; tick();
    end
    idle(); #1;
    n_cmp++;
    if (busy_1 !== 1'b0 || protocol_error !== 1'b0) begin
      n_err++; $display("FAIL zero_issue: busy_1=%b perr=%b, required 0 0", busy_1, protocol_error);
    end
  endtask

  task automatic test_same_cycle_and_error();
    idle(); issue_valid = 1; issue_idx = 9; tick();
    idle(); issue_valid = 1; issue_idx = 9; mem_valid = 1; mem_idx = 9; mem_data = 32'h99; tick();
    idle(); query_idx_2 = 9; #1;
    n_cmp++;
    if (busy_2 !== 1'b1 || protocol_error !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_idx9: busy_2=%b perr=%b, required 1 0", busy_2, protocol_error);
    end
    issue_valid = 1; issue_idx = 12; tick();
    issue_valid = 1; issue_idx = 12; tick();
    idle(); query_idx_1 = 12; tick(); tick(); #1;
    n_cmp++;
    if (protocol_error !== 1'b1 || busy_1 !== 1'b1) begin
      n_err++; $display("FAIL double_issue: perr=%b busy_1=%b, required 1 1 (sticky)", protocol_error, busy_1);
    end
  endtask

  task automatic test_reset_midcycle();
    idle(); issue_valid = 1; issue_idx = 7; tick();
    for (int c = 0; c < 4; c++) begin
      idle(); alu_valid = 1; alu_idx = 6; mem_valid = 1; mem_idx = 3; mem_data = 32'hCAFE_0000 + 32'(c);
      tick();
    end
    query_idx_1 = 7; query_idx_2 = 9; #1;
    n_cmp++;
    if (alu_ready !== 1'b1 || busy_1 !== 1'b1 || busy_2 !== 1'b1 || rf_write_enable !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: alu_ready=%b busy=%b%b we=%b, required 1 11 1",
                        alu_ready, busy_1, busy_2, rf_write_enable);
    end
    #1 reset = 1; #1;
    n_cmp++;
    if (rf_write_enable !== 1'b0 || rf_write_idx !== 5'd0 || rf_write_data !== 32'd0 ||
        protocol_error !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
      n_err++; $display("FAIL midcycle_reset: we=%b idx=%0d data=%h perr=%b alu_ready=%b mem_ready=%b, required 0 0 0 0 0 1",
                        rf_write_enable, rf_write_idx, rf_write_data, protocol_error, alu_ready, mem_ready);
    end
    for (int i = 0; i < 32; i++) begin
      query_idx_1 = 5'(i); #1;
      n_cmp++;
      if (busy_1 !== 1'b0) begin
        n_err++; $display("FAIL reset_busy_idx%0d: busy_1=%b, required 0", i, busy_1);
      end
    end
    idle();
    @(posedge clk); @(negedge clk);
    reset = 0; model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_valid   = ($urandom_range(0, 99) < 60);
      mem_valid   = ($urandom_range(0, 99) < 60);
      issue_valid = ($urandom_range(0, 99) < 30);
      alu_idx     = 5'($urandom_range(0, 31));
      mem_idx     = 5'($urandom_range(0, 7));
      issue_idx   = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      mem_data    = $urandom;
      query_idx_1 = 5'($urandom_range(0, 7));
      query_idx_2 = 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (alu_ready !== (model_grant() == 1) || mem_ready !== (model_grant() == 2) ||
          busy_1 !== m_pend[query_idx_1] || busy_2 !== m_pend[query_idx_2]) begin
        n_err++; $display("FAIL rand_comb c%0d: ready=%b%b busy=%b%b, required %b%b %b%b", c,
                          alu_ready, mem_ready, busy_1, busy_2, model_grant() == 1, model_grant() == 2,
                          m_pend[query_idx_1], m_pend[query_idx_2]);
      end
      tick();
      n_cmp++;
      if (rf_write_enable !== m_we || rf_write_idx !== m_idx || rf_write_data !== m_data ||
          protocol_error !== m_perr) begin
        n_err++; $display("FAIL rand_out c%0d: we=%b idx=%0d data=%h perr=%b, required %b %0d %h %b", c,
                          rf_write_enable, rf_write_idx, rf_write_data, protocol_error, m_we, m_idx, m_data, m_perr);
      end
    end
  endtask

  initial begin
    idle(); query_idx_1 = 0; query_idx_2 = 0;
    reset = 1; model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    test_reset();
    test_alu_alone();
    test_starvation();
    test_scoreboard();
    test_zero_reg();
    test_same_cycle_and_error();
    test_reset_midcycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
